// File: rtl/ones_generator.sv
// ones_generator: builds a WIDTH-bit word holding exactly N ones.
// The ones form one contiguous run that starts at start_pos and wraps from
// the MSB back to bit 0. One bit is set per clock under a three-state ASMD
// controller that uses the same start/done handshake as the bit counter.
module ones_generator #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CW    = $clog2(WIDTH + 1),
    parameter int unsigned PW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CW-1:0]    count,
    input  logic [PW-1:0]    start_pos,
    output logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // Largest legal ones-count; anything above it is flagged as an error.
    localparam logic [CW-1:0] MaxCount = CW'(WIDTH);
    localparam logic [PW-1:0] LastPos  = PW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e             r_state;
    logic [CW-1:0]      r_cnt;      // ones still to place
    logic [CW-1:0]      r_cnt_ld;   // count captured on the load edge
    logic [PW-1:0]      r_pos;      // next bit to set
    logic [WIDTH-1:0]   r_value;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_count_bad;
    logic [PW-1:0]      w_pos_next;

    // Combinational helpers: error detection and wrapping pointer increment.
    always_comb begin
        w_count_bad = (count > MaxCount);
        w_pos_next  = (r_pos == LastPos) ? '0 : r_pos + PW'(1);
    end

    // Controller and datapath: one always_ff, all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_cnt_ld <= '0;
            r_pos    <= '0;
            r_value  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_cnt    <= count;
                        r_cnt_ld <= count;
                        r_pos    <= start_pos;
                        r_value  <= '0;
                        if (w_count_bad) begin
                            // Out-of-range request: finish immediately with an empty word.
                            r_err   <= 1'b1;
                            r_state <= StDone;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= StRun;
                            r_busy  <= 1'b1;
                            r_done  <= 1'b0;
                        end
                    end
                end
                StRun: begin
                    if (r_cnt == '0) begin
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_value[r_pos] <= 1'b1;
                        r_pos          <= w_pos_next;
                        r_cnt          <= r_cnt - CW'(1);
                    end
                end
                StDone: begin
                    // Hold the result until the requester drops start.
                    if (!start) begin
                        r_state <= StIdle;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Output drive straight from the registers.
    always_comb begin
        value = r_value;
        busy  = r_busy;
        done  = r_done;
        err   = r_err;
    end

`ifndef SYNTHESIS
    // Every bit placed so far is one ones-count consumed.
    a_run_popcount: assert property (@(posedge clk) disable iff (reset)
        (r_state == StRun) |-> ($countones(r_value) + int'(r_cnt)) == int'(r_cnt_ld));

    // A clean finish holds exactly the requested number of ones.
    a_done_popcount: assert property (@(posedge clk) disable iff (reset)
        (r_state == StDone && !r_err) |-> $countones(r_value) == int'(r_cnt_ld));

    // Flags track the state one-for-one.
    a_busy_state: assert property (@(posedge clk) disable iff (reset)
        r_busy == (r_state == StRun));
    a_done_state: assert property (@(posedge clk) disable iff (reset)
        r_done == (r_state == StDone));
`endif

endmodule

// File: tb/tb_ones_generator.sv
// Self-checking bench for ones_generator: a counting model predicts the outputs
// every cycle, and directed tests pin key results with literal values.
module tb_ones_generator;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [CW-1:0] count;
    logic [PW-1:0] start_pos;
    logic [W-1:0]  value;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    ones_generator #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .count     (count),
        .start_pos (start_pos),
        .value     (value),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // The word after k placements is simply the first k positions of the run.
    function automatic logic [W-1:0] run_of(input int n, input int sp);
        logic [W-1:0] v = '0;
        for (int i = 0; i < n; i++) v[(sp + i) % W] = 1'b1;
        return v;
    endfunction

    typedef enum int {MIdle, MGen, MFin} mmode_t;
    mmode_t       m_mode;
    int           m_n, m_sp, m_j;
    logic         m_err;
    logic [W-1:0] m_val;

    // j counts edges since the load edge; done follows after N+1 of them.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = MIdle; m_n = 0; m_sp = 0; m_j = 0; m_err = 1'b0; m_val = '0;
        end else begin
            case (m_mode)
                MIdle: if (start === 1'b1) begin
                    m_n = int'(count); m_sp = int'(start_pos); m_j = 0; m_val = '0;
                    if (m_n > W) begin m_err = 1'b1; m_mode = MFin; end
                    else begin m_err = 1'b0; m_mode = MGen; end
                end
                MGen: begin
                    m_j++;
                    m_val = run_of((m_j < m_n) ? m_j : m_n, m_sp);
                    if (m_j == m_n + 1) m_mode = MFin;
                end
                MFin: if (start !== 1'b1) m_mode = MIdle;
                default: m_mode = MIdle;
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model, just after each edge.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("cyc_value", 32'(value), 32'(m_val));
            check("cyc_busy",  32'(busy),  32'(m_mode == MGen));
            check("cyc_done",  32'(done),  32'(m_mode == MFin));
            check("cyc_err",   32'(err),   32'(m_err));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_done(input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        check("done_within_budget", 32'(done), 32'd1);
    endtask

    // Pulse start for one load edge, scramble the inputs, wait for done.
    task automatic gen(input int n, input int sp, output logic [W-1:0] fin, output logic fin_err);
        @(negedge clk);
        count = CW'(n); start_pos = PW'(sp); start = 1'b1;
        @(negedge clk);
        start = 1'b0; count = 4'hF; start_pos = 3'h7;
        wait_done(20);
        fin = value;
        fin_err = err;
        @(negedge clk);
        check("back_to_idle_done", 32'(done), 32'd0);
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] r;
        logic         e;
        logic [W-1:0] steps [4];
        steps[0] = 8'h00; steps[1] = 8'h01; steps[2] = 8'h03; steps[3] = 8'h07;

        reset = 1'b1; start = 1'b0; count = '0; start_pos = '0;
        repeat (3) @(negedge clk);
        check("rst_value", 32'(value), 32'h00);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_err",   32'(err),   32'd0);
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // N=3 from bit 0: watch each step
        count = 4'd3; start_pos = 3'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("n3_step_value", 32'(value), 32'(steps[i]));
            check("n3_step_busy",  32'(busy),  32'd1);
            @(negedge clk);
        end
        check("n3_done",  32'(done),  32'd1);
        check("n3_value", 32'(value), 32'h07);
        @(negedge clk);

        gen(4, 6, r, e);  check("wrap_c3", 32'(r), 32'hC3);
        gen(8, 5, r, e);  check("full_ff", 32'(r), 32'hFF);
        gen(0, 2, r, e);  check("zero_00", 32'(r), 32'h00);

        // N=0: done right after one RUN edge
        @(negedge clk);
        count = 4'd0; start_pos = 3'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("n0_busy_after_load", 32'(busy), 32'd1);
        @(negedge clk);
        check("n0_done_after_1", 32'(done), 32'd1);
        @(negedge clk);

        // Error load: done immediately after the load edge
        count = 4'd9; start_pos = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("err_flag",  32'(err),   32'd1);
        check("err_done",  32'(done),  32'd1);
        check("err_value", 32'(value), 32'h00);
        @(negedge clk);
        gen(2, 3, r, e);
        check("after_err_value", 32'(r), 32'h18);
        check("after_err_clear", 32'(e), 32'd0);

        // start held through completion
        @(negedge clk);
        count = 4'd2; start_pos = 3'd0; start = 1'b1;
        wait_done(20);
        repeat (3) begin
            @(negedge clk);
            check("held_done", 32'(done), 32'd1);
        end
        start = 1'b0;
        @(negedge clk);
        check("held_release_done",  32'(done),  32'd0);
        check("held_release_value", 32'(value), 32'h03);

        // Reset in the middle of a run
        @(negedge clk);
        count = 4'd5; start_pos = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_value", 32'(value), 32'h00);
        check("midrst_busy",  32'(busy),  32'd0);
        check("midrst_done",  32'(done),  32'd0);
        check("midrst_err",   32'(err),   32'd0);
        @(negedge clk);
        reset = 1'b0;
        gen(5, 1, r, e);
        check("restart_3e", 32'(r), 32'h3E);

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
